// File: rtl/regblock_arbiter.sv
// Two-requester round-robin controller for an 8x8-bit register block.
// Executes READ/WRITE/COPY/SWAP commands and sequences the block's
// write/read ports. It returns a one-cycle done pulse and result data to
// the requester that owns the command.
module regblock_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [1:0] req0_op,
    input  logic [2:0] req0_src,
    input  logic [2:0] req0_dst,
    input  logic [7:0] req0_wdata,
    output logic       req0_ready,
    output logic       req0_done,
    output logic [7:0] req0_rdata,
    input  logic       req1_valid,
    input  logic [1:0] req1_op,
    input  logic [2:0] req1_src,
    input  logic [2:0] req1_dst,
    input  logic [7:0] req1_wdata,
    output logic       req1_ready,
    output logic       req1_done,
    output logic [7:0] req1_rdata,
    output logic       rf_we,
    output logic [2:0] rf_iaddr,
    output logic [7:0] rf_idata,
    output logic       rf_oe,
    output logic [2:0] rf_oaddr,
    input  logic [7:0] rf_odata
);

    typedef enum logic [1:0] {IDLE, EXEC, SWAP2, SWAP3} state_t;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_COPY, OP_SWAP} op_t;

    state_t     state, state_nx;
    op_t        cmd_op;
    logic [2:0] cmd_src, cmd_dst;
    logic [7:0] cmd_wdata;
    logic       owner;      // requester that owns the command in flight
    logic       last_grant; // requester granted most recently
    logic [7:0] tmp;        // first SWAP operand, held until SWAP3
    logic [7:0] result;
    logic       done0, done1;

    logic       winner;
    logic       accept;
    logic       fin;        // final exec cycle of the current command
    logic       res_load;
    logic [7:0] res_val;
    logic       tmp_load;

    // Arbitration: a lone valid requester wins; on contention the one not granted last wins.
    always_comb begin
        winner = req1_valid;
        if (req0_valid && req1_valid) begin
            winner = ~last_grant;
        end
        req0_ready = !rst && (state == IDLE) && req0_valid && !winner;
        req1_ready = !rst && (state == IDLE) && req1_valid && winner;
        accept     = req0_ready || req1_ready;
    end

    // Next-state and register-block pin sequencing; pins are held quiet while rst is high.
    always_comb begin
        state_nx = state;
        rf_we    = 1'b0;
        rf_iaddr = 3'd0;
        rf_idata = 8'd0;
        rf_oe    = 1'b0;
        rf_oaddr = 3'd0;
        fin      = 1'b0;
        res_load = 1'b0;
        res_val  = 8'd0;
        tmp_load = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (accept) state_nx = EXEC;
                end
                EXEC: begin
                    case (cmd_op)
                        OP_READ: begin
                            rf_oe    = 1'b1;
                            rf_oaddr = cmd_src;
                            res_load = 1'b1;
                            res_val  = rf_odata;
                            fin      = 1'b1;
                            state_nx = IDLE;
                        end
                        OP_WRITE: begin
                            rf_we    = 1'b1;
                            rf_iaddr = cmd_dst;
                            rf_idata = cmd_wdata;
                            res_load = 1'b1;
                            res_val  = cmd_wdata;
                            fin      = 1'b1;
                            state_nx = IDLE;
                        end
                        OP_COPY: begin
                            rf_oe    = 1'b1;
                            rf_oaddr = cmd_src;
                            rf_we    = 1'b1;
                            rf_iaddr = cmd_dst;
                            rf_idata = rf_odata;
                            res_load = 1'b1;
                            res_val  = rf_odata;
                            fin      = 1'b1;
                            state_nx = IDLE;
                        end
                        OP_SWAP: begin
                            rf_oe    = 1'b1;
                            rf_oaddr = cmd_src;
                            tmp_load = 1'b1;
                            state_nx = SWAP2;
                        end
                    endcase
                end
                SWAP2: begin
                    rf_oe    = 1'b1;
                    rf_oaddr = cmd_dst;
                    rf_we    = 1'b1;
                    rf_iaddr = cmd_src;
                    rf_idata = rf_odata;
                    res_load = 1'b1;
                    res_val  = rf_odata;
                    state_nx = SWAP3;
                end
                SWAP3: begin
                    rf_we    = 1'b1;
                    rf_iaddr = cmd_dst;
                    rf_idata = tmp;
                    fin      = 1'b1;
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // State, command latch, grant pointer, result/tmp capture and done pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmd_op     <= OP_READ;
            cmd_src    <= 3'd0;
            cmd_dst    <= 3'd0;
            cmd_wdata  <= 8'd0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            tmp        <= 8'd0;
            result     <= 8'd0;
            done0      <= 1'b0;
            done1      <= 1'b0;
        end else begin
            state <= state_nx;
            done0 <= fin && !owner;
            done1 <= fin && owner;
            if (accept) begin
                cmd_op     <= winner ? op_t'(req1_op) : op_t'(req0_op);
                cmd_src    <= winner ? req1_src : req0_src;
                cmd_dst    <= winner ? req1_dst : req0_dst;
                cmd_wdata  <= winner ? req1_wdata : req0_wdata;
                owner      <= winner;
                last_grant <= winner;
            end
            if (res_load) result <= res_val;
            if (tmp_load) tmp <= rf_odata;
        end
    end

    assign req0_done  = done0;
    assign req1_done  = done1;
    assign req0_rdata = result;
    assign req1_rdata = result;

endmodule

// File: tb/tb_regblock_arbiter.sv
// Bench for regblock_arbiter: an 8x8 register block, directed scenarios with
// literal expectations, randomized two-requester traffic and a
// command-level reference model checked every cycle.
module tb_regblock_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_mem = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [1:0] req0_op = 2'd0, req1_op = 2'd0;
    logic [2:0] req0_src = 3'd0, req0_dst = 3'd0, req1_src = 3'd0, req1_dst = 3'd0;
    logic [7:0] req0_wdata = 8'd0, req1_wdata = 8'd0;
    logic       req0_ready, req0_done, req1_ready, req1_done;
    logic [7:0] req0_rdata, req1_rdata;
    logic       rf_we, rf_oe;
    logic [2:0] rf_iaddr, rf_oaddr;
    logic [7:0] rf_idata, rf_odata;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int gq[$];

    regblock_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_src(req0_src),
        .req0_dst(req0_dst), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req0_done(req0_done), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_src(req1_src),
        .req1_dst(req1_dst), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .req1_done(req1_done), .req1_rdata(req1_rdata),
        .rf_we(rf_we), .rf_iaddr(rf_iaddr), .rf_idata(rf_idata),
        .rf_oe(rf_oe), .rf_oaddr(rf_oaddr), .rf_odata(rf_odata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register block: write commits on the clock edge, read is combinational.
    logic [7:0] mem [8];
    always @(posedge clk) begin
        if (rst_mem) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
        end else if (rf_we) begin
            mem[rf_iaddr] <= rf_idata;
        end
    end
    assign rf_odata = rf_oe ? mem[rf_oaddr] : 8'hEE;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Command-level reference model: expected registers, grants, done and result.
    logic [7:0] ref_rf [8];
    logic       m_busy = 1'b0;
    logic       m_last = 1'b1;
    logic       m_owner = 1'b0;
    int         m_pos = 0;
    int         m_lat = 0;
    logic [7:0] m_rdata = 8'h00;
    int         wr_n = 0;
    int         wr_off [2];
    logic [2:0] wr_addr [2];
    logic [7:0] wr_val [2];

    always @(negedge clk) begin
        logic ed0, ed1, win, er0, er1;
        logic [1:0] op;
        logic [2:0] s, d;
        logic [7:0] w;
        logic [63:0] pm, pr;
        ed0 = 1'b0;
        ed1 = 1'b0;
        if (rst_mem) begin
            for (int i = 0; i < 8; i++) ref_rf[i] = 8'h00;
            m_busy = 1'b0;
            m_last = 1'b1;
        end
        if (m_busy) begin
            m_pos++;
            if (m_pos == m_lat) begin
                m_busy = 1'b0;
                if (m_owner) ed1 = 1'b1; else ed0 = 1'b1;
            end
        end
        chk("done0", req0_done, ed0);
        chk("done1", req1_done, ed1);
        if (ed0) chk("rdata0", req0_rdata, m_rdata);
        if (ed1) chk("rdata1", req1_rdata, m_rdata);
        win = (req0_valid && req1_valid) ? !m_last : req1_valid;
        er0 = !rst && !m_busy && req0_valid && !win;
        er1 = !rst && !m_busy && req1_valid && win;
        chk("ready0", req0_ready, er0);
        chk("ready1", req1_ready, er1);
        if (!m_busy) begin
            chk("we_idle", rf_we, 1'b0);
            chk("oe_idle", rf_oe, 1'b0);
            for (int i = 0; i < 8; i++) begin
                pm[i*8 +: 8] = mem[i];
                pr[i*8 +: 8] = ref_rf[i];
            end
            chk("regs", pm, pr);
        end
        if (rst) begin
            m_busy = 1'b0;
            m_last = 1'b1;
        end else if (m_busy) begin
            for (int k = 0; k < wr_n; k++)
                if (wr_off[k] == m_pos) ref_rf[wr_addr[k]] = wr_val[k];
        end else if (er0 || er1) begin
            op = win ? req1_op : req0_op;
            s  = win ? req1_src : req0_src;
            d  = win ? req1_dst : req0_dst;
            w  = win ? req1_wdata : req0_wdata;
            m_owner = win;
            m_last  = win;
            m_busy  = 1'b1;
            m_pos   = 0;
            wr_n    = 0;
            m_lat   = 2;
            case (op)
                2'd0: m_rdata = ref_rf[s];
                2'd1: begin
                    m_rdata = w;
                    wr_n = 1; wr_off[0] = 1; wr_addr[0] = d; wr_val[0] = w;
                end
                2'd2: begin
                    m_rdata = ref_rf[s];
                    wr_n = 1; wr_off[0] = 1; wr_addr[0] = d; wr_val[0] = ref_rf[s];
                end
                default: begin
                    m_lat = 4;
                    m_rdata = ref_rf[d];
                    wr_n = 2;
                    wr_off[0] = 2; wr_addr[0] = s; wr_val[0] = ref_rf[d];
                    wr_off[1] = 3; wr_addr[1] = d; wr_val[1] = ref_rf[s];
                end
            endcase
        end
    end

    // Present a command, hold it until accepted; returns the acceptance cycle.
    task automatic issue(input int n, input logic [1:0] op, input logic [2:0] s,
                         input logic [2:0] d, input logic [7:0] w, output int acc);
        int k;
        logic rdy;
        if (n == 0) begin
            req0_op = op; req0_src = s; req0_dst = d; req0_wdata = w; req0_valid = 1'b1;
        end else begin
            req1_op = op; req1_src = s; req1_dst = d; req1_wdata = w; req1_valid = 1'b1;
        end
        k = 0;
        acc = -1;
        @(negedge clk);
        rdy = (n == 0) ? req0_ready : req1_ready;
        while (!rdy && k < 50) begin
            @(negedge clk);
            rdy = (n == 0) ? req0_ready : req1_ready;
            k++;
        end
        if (!rdy) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: requester %0d got no ready, required ready within 50 cycles", n);
        end else begin
            acc = cyc;
            gq.push_back(n);
        end
        @(posedge clk);
        #1;
        if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    // Wait for the owner's done pulse; checks latency and returns rdata.
    task automatic wait_done(input int n, input int acc, input int lat, output logic [7:0] rd);
        int k;
        logic dn;
        k = 0;
        rd = 8'h00;
        @(negedge clk);
        dn = (n == 0) ? req0_done : req1_done;
        while (!dn && k < 10) begin
            @(negedge clk);
            dn = (n == 0) ? req0_done : req1_done;
            k++;
        end
        chk("done_seen", dn, 1'b1);
        if (dn) begin
            chk("latency", cyc - acc, lat);
            rd = (n == 0) ? req0_rdata : req1_rdata;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required completion before 10000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1;
        logic [7:0] rd;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        rst_mem = 1'b0;
        @(negedge clk);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_oe", rf_oe, 1'b0);
        chk("rst_rf_addr", {rf_iaddr, rf_oaddr}, 6'd0);
        chk("rst_rf_idata", rf_idata, 8'd0);
        chk("rst_rdata", {req0_rdata, req1_rdata}, 16'd0);
        @(posedge clk);
        #1;

        // Write then read back.
        issue(0, 2'd1, 3'd0, 3'd3, 8'hA5, a0);
        wait_done(0, a0, 2, rd);
        chk("write_rdata", rd, 8'hA5);
        chk("write_mem3", mem[3], 8'hA5);
        issue(0, 2'd0, 3'd3, 3'd0, 8'h00, a0);
        wait_done(0, a0, 2, rd);
        chk("read_rdata", rd, 8'hA5);

        // Copy and swap.
        issue(0, 2'd1, 3'd0, 3'd1, 8'h11, a0);
        wait_done(0, a0, 2, rd);
        issue(1, 2'd1, 3'd0, 3'd2, 8'h22, a0);
        wait_done(1, a0, 2, rd);
        issue(0, 2'd2, 3'd1, 3'd4, 8'h00, a0);
        wait_done(0, a0, 2, rd);
        chk("copy_rdata", rd, 8'h11);
        chk("copy_mem4", mem[4], 8'h11);
        issue(0, 2'd3, 3'd1, 3'd2, 8'h00, a0);
        wait_done(0, a0, 4, rd);
        chk("swap_rdata", rd, 8'h22);
        chk("swap_mem1", mem[1], 8'h22);
        chk("swap_mem2", mem[2], 8'h11);

        // Contention: req1 arrives during req0's SWAP.
        fork
            issue(0, 2'd3, 3'd1, 3'd2, 8'h00, a0);
            begin
                @(posedge clk);
                #1;
                issue(1, 2'd0, 3'd4, 3'd0, 8'h00, a1);
            end
        join
        chk("contend_accept_gap", a1 - a0, 4);
        wait_done(1, a1, 2, rd);
        chk("contend_rdata", rd, 8'h11);

        // SWAP with src == dst.
        issue(1, 2'd1, 3'd0, 3'd7, 8'h3C, a0);
        wait_done(1, a0, 2, rd);
        issue(1, 2'd3, 3'd7, 3'd7, 8'h00, a0);
        wait_done(1, a0, 4, rd);
        chk("swap77_rdata", rd, 8'h3C);
        chk("swap77_mem7", mem[7], 8'h3C);

        // Reset during SWAP3.
        issue(0, 2'd1, 3'd0, 3'd5, 8'h55, a0);
        wait_done(0, a0, 2, rd);
        issue(0, 2'd1, 3'd0, 3'd6, 8'h66, a0);
        wait_done(0, a0, 2, rd);
        issue(0, 2'd3, 3'd5, 3'd6, 8'h00, a0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_done", {req0_done, req1_done}, 2'b00);
        chk("midrst_pins", {rf_we, rf_oe, rf_iaddr, rf_oaddr, rf_idata}, 16'd0);
        chk("midrst_rdata", req0_rdata, 8'h00);
        chk("midrst_mem5", mem[5], 8'h66);
        chk("midrst_mem6", mem[6], 8'h66);
        @(posedge clk);
        #1;

        // Round-robin with both requesters continuously valid.
        gq.delete();
        fork
            for (int i = 0; i < 3; i++) issue(0, 2'd0, 3'd0, 3'd0, 8'h00, a0);
            for (int j = 0; j < 3; j++) issue(1, 2'd0, 3'd1, 3'd0, 8'h00, a1);
        join
        chk("rr_count", gq.size(), 6);
        for (int i = 0; i < 6 && i < gq.size(); i++) chk("rr_order", gq[i], i % 2);
        chk("rr_spacing", a1 - a0, 2);
        repeat (4) @(posedge clk);
        #1;

        // Randomized traffic from both requesters.
        fork
            for (int i = 0; i < 40; i++) begin
                int t;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                issue(0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), t);
            end
            for (int j = 0; j < 40; j++) begin
                int t;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                issue(1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), t);
            end
        join
        repeat (8) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
